set_assoc_cache_ctrl: RTL

//  Parametrised 2-way set-associative read cache between the MEM stage and the SRAM controller.

---
 rtl/cache_pkg.sv | 31 +++
 rtl/cache_way.sv | 51 +++++
 rtl/set_assoc_cache_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared FSM state type and address field extraction for the 2-way read cache
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Widest byte address the field extractor handles.
    localparam int FIELD_MAX = 64;

    // Byte offset inside a word is always two bits wide.
    localparam int WORD_LO = 2;

    // Bit fields of the default geometry (2 words/line, 64 sets).
    localparam int DEF_WORD_W = $clog2(2);
    localparam int DEF_IDX_W  = $clog2(64);

    // Returns w bits of a starting at bit lo, zero-extended to FIELD_MAX.
    function automatic logic [FIELD_MAX-1:0] addr_field(
        input logic [FIELD_MAX-1:0] a,
        input int                   lo,
        input int                   w
    );
        logic [FIELD_MAX-1:0] mask;
        mask = (FIELD_MAX'(1) << w) - FIELD_MAX'(1);
        return (a >> lo) & mask;
    endfunction

endpackage

// File: rtl/cache_way.sv
// rtl/cache_way.sv - one cache way: valid/tag/data arrays, hit compare, line/word write and invalidate-all
module cache_way #(
    parameter int SETS       = 64,
    parameter int TAG_W      = 10,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 2
) (
    input  logic                          clk,         // rising-edge clock
    input  logic                          rst,         // sync active-high, clears valids
    input  logic                          inv_all,     // flush: clear every valid bit
    input  logic [$clog2(SETS)-1:0]       idx,         // set index of the current request
    input  logic [TAG_W-1:0]              tag,         // tag of the current request
    output logic                          hit,         // valid and tag match at idx
    output logic                          valid_at,    // valid bit at idx
    output logic [LINE_WORDS*DATA_W-1:0]  line,        // stored line at idx
    input  logic                          line_we,     // write full line, tag, set valid
    input  logic [LINE_WORDS*DATA_W-1:0]  line_wdata,  // fill line
    input  logic                          word_we,     // overwrite one word of the line at idx
    input  logic [$clog2(LINE_WORDS)-1:0] word_sel,    // word within the line
    input  logic [DATA_W-1:0]             word_wdata   // replacement word
);
    localparam int LINE_W = LINE_WORDS * DATA_W;

    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tag_mem  [SETS];
    logic [LINE_W-1:0] data_mem [SETS];

    assign valid_at = valid[idx];
    assign hit      = valid[idx] && (tag_mem[idx] == tag);
    assign line     = data_mem[idx];

    // A fill in the same cycle as a flush survives: the later assignment wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (inv_all) valid <= '0;
            if (line_we) valid[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[idx]  <= tag;
            data_mem[idx] <= line_wdata;
        end else if (word_we) begin
            data_mem[idx][word_sel*DATA_W +: DATA_W] <= word_wdata;
        end
    end

endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// rtl/set_assoc_cache_ctrl.sv - 2-way set-associative read-allocate write-through cache controller
module set_assoc_cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 2,
    parameter int TAG_W      = 10
) (
    input  logic                         clk,         // rising-edge clock
    input  logic                         rst,         // sync active-high reset
    input  logic                         rd_en,       // CPU read, held until ready
    input  logic                         wr_en,       // CPU write, held until ready
    input  logic [ADDR_W-1:0]            addr,        // CPU byte address
    input  logic [DATA_W-1:0]            wdata,       // CPU write data
    output logic [DATA_W-1:0]            rdata,       // read data, valid with ready&rd_en
    output logic                         ready,       // request completes this cycle
    input  logic                         flush,       // invalidate all lines
    output logic                         sram_rd_en,  // line read, held until sram_ready
    output logic                         sram_wr_en,  // word write, held until sram_ready
    output logic [ADDR_W-1:0]            sram_addr,   // line-aligned on read, addr on write
    output logic [DATA_W-1:0]            sram_wdata,  // write data to SRAM
    input  logic [LINE_WORDS*DATA_W-1:0] sram_rdata,  // fill line, word k at [k*DATA_W +: DATA_W]
    input  logic                         sram_ready,  // SRAM completes current request
    output logic [31:0]                  hit_cnt,     // read hits, wraps
    output logic [31:0]                  miss_cnt     // read misses, wraps
);
    localparam int WORD_W = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(SETS);
    localparam int LINE_W = LINE_WORDS * DATA_W;
    localparam int IDX_LO = WORD_LO + WORD_W;
    localparam int TAG_LO = IDX_LO + IDX_W;

    state_t state, next_state;

    logic [FIELD_MAX-1:0] addr_ext, word_f, idx_f, tag_f;
    logic [WORD_W-1:0]    word;
    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic                 unused_bits;

    assign addr_ext    = FIELD_MAX'(addr);
    assign word_f      = addr_field(addr_ext, WORD_LO, WORD_W);
    assign idx_f       = addr_field(addr_ext, IDX_LO, IDX_W);
    assign tag_f       = addr_field(addr_ext, TAG_LO, TAG_W);
    assign word        = word_f[WORD_W-1:0];
    assign idx         = idx_f[IDX_W-1:0];
    assign tag         = tag_f[TAG_W-1:0];
    assign unused_bits = ^{word_f[FIELD_MAX-1:WORD_W], idx_f[FIELD_MAX-1:IDX_W], tag_f[FIELD_MAX-1:TAG_W]};

    logic              hit0, hit1, valid0, valid1, hit, victim;
    logic [LINE_W-1:0] line0, line1, hit_line;
    logic [DATA_W-1:0] hit_word, fill_word;
    logic [SETS-1:0]   lru;   // per set: the way to evict next
    logic              fill_we, word_we, hit_inc, miss_inc;

    assign hit       = hit0 | hit1;
    assign hit_line  = hit1 ? line1 : line0;
    assign hit_word  = hit_line[word*DATA_W +: DATA_W];
    assign fill_word = sram_rdata[word*DATA_W +: DATA_W];
    // Free ways fill first (way0 before way1); only a full set consults lru.
    assign victim    = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru[idx]);

    cache_way #(.SETS(SETS), .TAG_W(TAG_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS)) u_way0 (
        .clk(clk), .rst(rst), .inv_all(flush), .idx(idx), .tag(tag),
        .hit(hit0), .valid_at(valid0), .line(line0),
        .line_we(fill_we & ~victim), .line_wdata(sram_rdata),
        .word_we(word_we & hit0), .word_sel(word), .word_wdata(wdata)
    );

    cache_way #(.SETS(SETS), .TAG_W(TAG_W), .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS)) u_way1 (
        .clk(clk), .rst(rst), .inv_all(flush), .idx(idx), .tag(tag),
        .hit(hit1), .valid_at(valid1), .line(line1),
        .line_we(fill_we & victim), .line_wdata(sram_rdata),
        .word_we(word_we & hit1), .word_sel(word), .word_wdata(wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (wr_en)              next_state = ST_WRITE;
                else if (rd_en && !hit) next_state = ST_FILL;
            end
            ST_FILL:  if (sram_ready) next_state = ST_IDLE;
            ST_WRITE: if (sram_ready) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Outputs and update strobes are suppressed during rst so an in-flight
    // SRAM completion is dropped.
    always_comb begin
        ready      = 1'b0;
        rdata      = '0;
        sram_rd_en = 1'b0;
        sram_wr_en = 1'b0;
        sram_addr  = addr;
        sram_wdata = wdata;
        fill_we    = 1'b0;
        word_we    = 1'b0;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    if (!wr_en && rd_en) begin
                        if (hit) begin
                            ready   = 1'b1;
                            rdata   = hit_word;
                            hit_inc = 1'b1;
                        end else begin
                            miss_inc = 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    sram_rd_en = 1'b1;
                    sram_addr  = {addr[ADDR_W-1:IDX_LO], IDX_LO'(0)};
                    if (sram_ready) begin
                        fill_we = 1'b1;
                        ready   = rd_en;
                        rdata   = rd_en ? fill_word : '0;
                    end
                end
                ST_WRITE: begin
                    sram_wr_en = 1'b1;
                    if (sram_ready) begin
                        ready   = wr_en;
                        word_we = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lru      <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_inc) begin
                hit_cnt  <= hit_cnt + 32'd1;
                lru[idx] <= ~hit1;
            end
            if (miss_inc) miss_cnt <= miss_cnt + 32'd1;
            if (fill_we)  lru[idx] <= ~victim;
        end
    end

endmodule
